twid_addr_gen: RTL and testbench
================================

# twid_addr_gen

Twiddle-ROM address generator for one stage of the single-path delay-feedback FFT pipeline, with the FFT length selectable at runtime.
- Owns the per-stage butterfly counter and latches frame configuration on start-of-frame.
- Emits a pipelined, valid-qualified twiddle ROM address plus conjugate and rotation flags.
- Sits between the stage's input data path and its twiddle ROM/complex multiplier; one instance per stage.

## Interface

Parameters:
- `MAX_FFT_SIZE`, 1024: largest supported FFT length; power of two, ≥ 8. W = log2(MAX_FFT_SIZE).
- `NUM_STAGE`, 1: stage index counted at max size; 1 ≤ NUM_STAGE ≤ W-1.
- `LATENCY`, 2: register stages from input to output; 0..8.

Ports (CW = clog2(W+1); AW = W-1, or W-2 with `TWID_QUARTER_ROM_EN`):
- `clk` in 1: clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_valid` in 1: one twiddle beat is requested this cycle.
- `s_sof` in 1: first beat of a frame; qualified by `s_valid`.
- `cfg_log2n` in CW: log2 of the runtime FFT length L; sampled on `s_valid && s_sof`.
- `cfg_inverse` in 1: inverse-FFT frame; sampled on `s_valid && s_sof`.
- `m_valid` out 1: output beat valid.
- `m_addr` out AW: twiddle ROM address, in units of the MAX_FFT_SIZE table.
- `m_rot` out 1: downstream multiplies the ROM value by -j (quarter-ROM fold).
- `m_conj` out 1: downstream conjugates the twiddle (inverse frame).
- `cfg_err` out 1: sticky flag, set when the last latched `cfg_log2n` was out of range.

## Operation

- Configuration is latched on `s_valid && s_sof` as Lr (cfg_log2n), Inv, and err.
  - Legal range is 3 ≤ cfg_log2n ≤ W.
  - Out of range: Lr is clamped to W and err = 1. A legal value clears err.
- Counter `cnt` is W-1 bits and counts beats modulo 2^(Lr-1).
  - On `s_valid && s_sof`: the beat uses cnt = 0 and the frame's new configuration; the next cnt is 1.
  - On `s_valid` alone: the beat uses the current cnt, then cnt increments and wraps to 0 after 2^(Lr-1)-1.
  - No `s_valid`: cnt holds.
- Index math for the beat, with M = Lr-1:
  - If NUM_STAGE > M (stage unused at this length): idx = 0.
  - Otherwise: r = cnt rotated left by 1 within M bits; idx = (r << (NUM_STAGE-1)) mod 2^M.
  - Full address: fa = idx << (W-Lr), in the range 0..MAX/2-1.
- Full-address output (no macro): m_addr = fa; m_rot = 0.
- `m_conj` = Inv, taken from the configuration in force for that beat.
- Changes to `cfg_*` without a qualifying `s_sof` are ignored.

## Timing

- Every output (m_valid, m_addr, m_rot, m_conj) is delayed by exactly LATENCY cycles from the `s_valid` cycle, and all of them stay aligned.
- LATENCY = 0: outputs are combinational from `s_valid`, `s_sof`, `cfg_*` and the registered state.
- Throughput is one beat per cycle; back-to-back `s_sof` is legal and each one restarts the frame.
- `cfg_err` updates on the cycle after the latching beat and is not pipelined.
- Reset values:
  - Outputs: m_valid, m_addr, m_rot, m_conj, cfg_err = 0.
  - Internal state: cnt = 0, Lr = W, Inv = 0, pipeline cleared.
- Reset mid-frame drops all in-flight beats. Beats after reset without an `s_sof` use the reset defaults (N = MAX, forward).
- When `m_valid` is 0, the values of `m_addr`, `m_rot` and `m_conj` are don't-care, but they must not be X after reset.

## Configuration

- `TWID_QUARTER_ROM_EN` defined:
  - AW = W-2, so the ROM holds MAX/4 entries.
  - fa < MAX/4: m_addr = fa, m_rot = 0.
  - Otherwise: m_addr = fa - MAX/4, m_rot = 1.
- `TWID_QUARTER_ROM_EN` undefined:
  - AW = W-1, so the ROM holds MAX/2 entries.
  - m_rot is tied to 0.
  - All other behaviour is identical.

## Test plan

- MAX=32, NUM_STAGE=1, LATENCY=2, sof with log2n=5, then 16 beats:
  - cnt=1 → m_addr 2; cnt=8 → m_addr 1.
  - Each result appears 2 cycles after its beat.
  - The sequence wraps after 16 beats.
- MAX=32, NUM_STAGE=2, log2n=5: cnt=3 → m_addr 12; cnt=8 → m_addr 2.
  - With the macro: cnt=3 → m_addr 4, m_rot 1.
- MAX=32, NUM_STAGE=1, log2n=4:
  - cnt=5 → m_addr 6.
  - The counter wraps after 8 beats.
  - With NUM_STAGE=4 the stage is unused, so every beat gives m_addr 0.
- Mid-frame reconfiguration and error flag:
  - cfg_inverse toggled mid-frame: no change to m_conj until the next sof.
  - sof with cfg_inverse=1 and log2n=7: m_conj=1, cfg_err=1, length behaves as 32.
  - Next sof with log2n=5: cfg_err clears.
- Reset and gapped input:
  - rst_n asserted with 2 beats in flight: m_valid=0 immediately and no stale beats emerge.
  - Gapped `s_valid`: cnt holds across the idle cycles.
- LATENCY=0: outputs equal the same-cycle combinational result, and a sof beat reports m_addr 0.

Source files
------------

// File: rtl/twid_addr_gen.sv
// Twiddle-ROM address generator for one SDF FFT stage with a runtime FFT length.
// Define TWID_QUARTER_ROM_EN to fold addresses into a quarter-size ROM with a -j rotate flag.
module twid_addr_gen #(
    parameter int MAX_FFT_SIZE = 1024,
    parameter int NUM_STAGE    = 1,
    parameter int LATENCY      = 2,
    localparam int W  = $clog2(MAX_FFT_SIZE),
    localparam int CW = $clog2(W + 1),
`ifdef TWID_QUARTER_ROM_EN
    localparam int AW = W - 2
`else
    localparam int AW = W - 1
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    input  logic          s_sof,
    input  logic [CW-1:0] cfg_log2n,
    input  logic          cfg_inverse,
    output logic          m_valid,
    output logic [AW-1:0] m_addr,
    output logic          m_rot,
    output logic          m_conj,
    output logic          cfg_err
);
    localparam int PW = AW + 2;

    logic [W-2:0]  cnt_q, cnt_d, cnt_b, mask, rot_cnt, idx, fa;
    logic [CW-1:0] lr_q, lr_d, lr_b, m_len;
    logic          inv_q, inv_d, inv_b, err_q, err_d;
    logic          sof, legal;
    logic [AW-1:0] addr;
    logic          rot;
    logic [PW-1:0] beat_pay;

    // A sof beat uses its own configuration and cnt = 0 in the same cycle.
    always_comb begin
        sof   = s_valid && s_sof;
        legal = (cfg_log2n >= CW'(3)) && (cfg_log2n <= CW'(W));
        lr_b  = lr_q;
        inv_b = inv_q;
        cnt_b = cnt_q;
        if (sof) begin
            lr_b  = legal ? cfg_log2n : CW'(W);
            inv_b = cfg_inverse;
            cnt_b = '0;
        end
        m_len   = lr_b - CW'(1);
        mask    = ~({(W-1){1'b1}} << m_len);
        rot_cnt = ((cnt_b << 1) | (cnt_b >> (m_len - CW'(1)))) & mask;
        idx     = (NUM_STAGE > int'(m_len)) ? '0 : ((rot_cnt << (NUM_STAGE - 1)) & mask);
        fa      = idx << (CW'(W) - lr_b);

        cnt_d = cnt_q;
        lr_d  = lr_q;
        inv_d = inv_q;
        err_d = err_q;
        if (s_valid) begin
            cnt_d = (cnt_b == mask) ? '0 : cnt_b + (W-1)'(1);
            lr_d  = lr_b;
            inv_d = inv_b;
        end
        if (sof) err_d = !legal;
    end

`ifdef TWID_QUARTER_ROM_EN
    // Upper half of the half-table maps onto the quarter table times -j.
    assign rot  = fa[W-2];
    assign addr = fa[W-3:0];
`else
    assign rot  = 1'b0;
    assign addr = fa;
`endif
    assign beat_pay = {rot, inv_b, addr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            lr_q  <= CW'(W);
            inv_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lr_q  <= lr_d;
            inv_q <= inv_d;
            err_q <= err_d;
        end
    end

    assign cfg_err = err_q;

    generate
        if (LATENCY == 0) begin : g_comb
            assign m_valid               = s_valid;
            assign {m_rot, m_conj, m_addr} = beat_pay;
        end else begin : g_pipe
            logic [LATENCY-1:0]         vld_pipe_q;
            logic [LATENCY-1:0][PW-1:0] pay_pipe_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pipe_q <= '0;
                    pay_pipe_q <= '0;
                end else begin
                    vld_pipe_q[0] <= s_valid;
                    pay_pipe_q[0] <= beat_pay;
                    for (int i = 1; i < LATENCY; i++) begin
                        vld_pipe_q[i] <= vld_pipe_q[i-1];
                        pay_pipe_q[i] <= pay_pipe_q[i-1];
                    end
                end
            end

            assign m_valid               = vld_pipe_q[LATENCY-1];
            assign {m_rot, m_conj, m_addr} = pay_pipe_q[LATENCY-1];
        end
    endgenerate
endmodule

// File: tb/tb_twid_addr_gen.sv
// Scoreboard bench: three stage/latency variants of twid_addr_gen share one stimulus stream.
module tb_twid_addr_gen;
    localparam int W  = 5;
    localparam int CW = 3;
`ifdef TWID_QUARTER_ROM_EN
    localparam int AW = W - 2;
`else
    localparam int AW = W - 1;
`endif

    typedef struct {
        int cyc;
        int addr;
        int rot;
        int conj;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_sof = 1'b0;
    logic [CW-1:0] cfg_log2n = '0;
    logic          cfg_inverse = 1'b0;

    logic          m_valid_a, m_rot_a, m_conj_a, cfg_err_a;
    logic          m_valid_b, m_rot_b, m_conj_b, cfg_err_b;
    logic          m_valid_c, m_rot_c, m_conj_c, cfg_err_c;
    logic [AW-1:0] m_addr_a, m_addr_b, m_addr_c;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb_a[$], sb_b[$], sb_c[$];
    exp_t e;

    // bench-side reference state
    int t_cnt = 0, t_lr = 5, t_inv = 0, t_err = 0;

    twid_addr_gen #(.MAX_FFT_SIZE(32), .NUM_STAGE(1), .LATENCY(2)) u_a (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_sof(s_sof),
        .cfg_log2n(cfg_log2n), .cfg_inverse(cfg_inverse),
        .m_valid(m_valid_a), .m_addr(m_addr_a), .m_rot(m_rot_a),
        .m_conj(m_conj_a), .cfg_err(cfg_err_a));

    twid_addr_gen #(.MAX_FFT_SIZE(32), .NUM_STAGE(2), .LATENCY(0)) u_b (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_sof(s_sof),
        .cfg_log2n(cfg_log2n), .cfg_inverse(cfg_inverse),
        .m_valid(m_valid_b), .m_addr(m_addr_b), .m_rot(m_rot_b),
        .m_conj(m_conj_b), .cfg_err(cfg_err_b));

    twid_addr_gen #(.MAX_FFT_SIZE(32), .NUM_STAGE(4), .LATENCY(1)) u_c (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_sof(s_sof),
        .cfg_log2n(cfg_log2n), .cfg_inverse(cfg_inverse),
        .m_valid(m_valid_c), .m_addr(m_addr_c), .m_rot(m_rot_c),
        .m_conj(m_conj_c), .cfg_err(cfg_err_c));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (cyc %0d)", nm, act, req, cyc);
        end
    endfunction

    // Arithmetic reference: rotate-left-by-one within M bits, then scale to the 32-entry table.
    function automatic exp_t model(int stage, int lat, int lr, int c, int inv);
        exp_t r;
        int m, rc, idx, fa;
        m = lr - 1;
        if (stage > m) idx = 0;
        else begin
            rc  = ((c * 2) % (1 << m)) + (c >> (m - 1));
            idx = (rc * (1 << (stage - 1))) % (1 << m);
        end
        fa = idx * (1 << (W - lr));
        r.cyc  = cyc + lat;
        r.conj = inv;
`ifdef TWID_QUARTER_ROM_EN
        if (fa >= 8) begin r.addr = fa - 8; r.rot = 1; end
        else         begin r.addr = fa;     r.rot = 0; end
`else
        r.addr = fa;
        r.rot  = 0;
`endif
        return r;
    endfunction

    function automatic void cmp_beat(string nm, exp_t x, int addr, int rot, int conj);
        chk({nm, "_lat"}, cyc, x.cyc);
        chk({nm, "_addr"}, addr, x.addr);
        chk({nm, "_rot"}, rot, x.rot);
        chk({nm, "_conj"}, conj, x.conj);
    endfunction

    // monitor: sampled on the falling edge, away from input changes and the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_a.delete();
            sb_b.delete();
            sb_c.delete();
            chk("rst_vld_a", int'(m_valid_a), 0);
            chk("rst_vld_b", int'(m_valid_b), 0);
            chk("rst_vld_c", int'(m_valid_c), 0);
            chk("rst_addr_a", int'(m_addr_a), 0);
            chk("rst_err_a", int'(cfg_err_a), 0);
        end else begin
            if (m_valid_a) begin
                if (sb_a.size() == 0) chk("stray_a", 1, 0);
                else begin e = sb_a.pop_front(); cmp_beat("a", e, int'(m_addr_a), int'(m_rot_a), int'(m_conj_a)); end
            end
            if (m_valid_b) begin
                if (sb_b.size() == 0) chk("stray_b", 1, 0);
                else begin e = sb_b.pop_front(); cmp_beat("b", e, int'(m_addr_b), int'(m_rot_b), int'(m_conj_b)); end
            end
            if (m_valid_c) begin
                if (sb_c.size() == 0) chk("stray_c", 1, 0);
                else begin e = sb_c.pop_front(); cmp_beat("c", e, int'(m_addr_c), int'(m_rot_c), int'(m_conj_c)); end
            end
        end
    end

    task automatic beat(bit sof, int l2n, bit inv);
        if (sof) begin
            t_err = (l2n >= 3 && l2n <= W) ? 0 : 1;
            t_lr  = t_err ? W : l2n;
            t_inv = int'(inv);
            t_cnt = 0;
        end
        sb_a.push_back(model(1, 2, t_lr, t_cnt, t_inv));
        sb_b.push_back(model(2, 0, t_lr, t_cnt, t_inv));
        sb_c.push_back(model(4, 1, t_lr, t_cnt, t_inv));
        t_cnt = (t_cnt + 1) % (1 << (t_lr - 1));
        s_valid     = 1'b1;
        s_sof       = sof;
        cfg_log2n   = CW'(l2n);
        cfg_inverse = inv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(int n);
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        t_cnt = 0; t_lr = W; t_inv = 0; t_err = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        chk("err_after_rst", int'(cfg_err_a), 0);
    endtask

    initial begin
        do_reset(3);

        // full length: 16-beat frame plus wrap
        beat(1, 5, 0);
        chk("err_l5", int'(cfg_err_a), t_err);
        for (int i = 1; i < 18; i++) beat(0, 5, 0);

        // N=16; mid-frame cfg changes (inverse, bogus length) must be ignored
        beat(1, 4, 0);
        for (int i = 0; i < 9; i++) beat(0, 7, 1);

        // out-of-range length: clamp to 32, inverse, sticky error
        beat(1, 7, 1);
        chk("err_set_a", int'(cfg_err_a), 1);
        chk("err_set_b", int'(cfg_err_b), 1);
        for (int i = 0; i < 6; i++) beat(0, 3, 0);
        beat(1, 2, 0);
        chk("err_low", int'(cfg_err_a), 1);
        beat(1, 5, 0);
        chk("err_clr", int'(cfg_err_a), 0);

        // gapped input holds cnt
        beat(0, 5, 0);
        idle(2);
        beat(0, 5, 1);
        idle(1);
        beat(0, 5, 0);
        beat(0, 5, 0);

        // smallest legal length, back-to-back sof
        beat(1, 3, 1);
        beat(1, 3, 1);
        for (int i = 0; i < 5; i++) beat(0, 3, 0);
        chk("err_l3", int'(cfg_err_c), 0);

        // reset with beats in flight, then beats on reset defaults
        beat(1, 4, 1);
        beat(0, 4, 1);
        do_reset(2);
        for (int i = 0; i < 3; i++) beat(0, 4, 1);

        idle(4);
        chk("drain_a", sb_a.size(), 0);
        chk("drain_b", sb_b.size(), 0);
        chk("drain_c", sb_c.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
